pc_scheduler: RTL

- Thread scheduler that sits directly around basic_block.
  - Feeds basic_block's input_pc channel.
  - Consumes basic_block's output_pc channel, including its is_directed_to_current flag.
- Holds two PC queues in ping-pong fashion:
  - the "current" queue holds threads for the character being examined;
  - the "next" queue holds threads waiting for the following character.
- Decides when the current character is exhausted, requests a character advance, detects acceptance/termination and reports the match result.

---
 rtl/pc_scheduler_pkg.sv | 6 +
 rtl/pc_scheduler_if.sv | 21 ++
 rtl/pc_scheduler_fifo.sv | 40 ++++
 rtl/pc_scheduler.sv | 94 +++++++++
 4 files changed

// File: rtl/pc_scheduler_pkg.sv
// pc_scheduler_pkg: scheduler state type and default sizing shared by the pc_scheduler files
package pc_scheduler_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ADVANCE, S_DONE} state_e;
  localparam int DEFAULT_PC_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH_LOG2 = 4;
endpackage

// File: rtl/pc_scheduler_if.sv
// pc_scheduler_if: PC channels between basic_block (master) and pc_scheduler (slave)
// in_pc_*: produced PCs into the scheduler; out_pc_*: PCs offered to basic_block input_pc
interface pc_scheduler_if import pc_scheduler_pkg::*; #(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH
);
  logic                in_pc_valid;
  logic [PC_WIDTH-1:0] in_pc;
  logic                in_pc_is_directed_to_current;
  logic                in_pc_ready;
  logic                out_pc_valid;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_pc_ready;
  modport master (
    output in_pc_valid, in_pc, in_pc_is_directed_to_current, out_pc_ready,
    input  in_pc_ready, out_pc_valid, out_pc
  );
  modport slave (
    input  in_pc_valid, in_pc, in_pc_is_directed_to_current, out_pc_ready,
    output in_pc_ready, out_pc_valid, out_pc
  );
endinterface

// File: rtl/pc_scheduler_fifo.sv
// pc_fifo: registered PC queue with push/pop/clear; clear and push together restart it holding one entry
// ports: clk, reset (sync, active-low), clear, push, pop, din -> head, full, empty
module pc_fifo import pc_scheduler_pkg::*; #(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter int FIFO_DEPTH_LOG2 = DEFAULT_FIFO_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] din,
  output logic [PC_WIDTH-1:0] head,
  output logic                full,
  output logic                empty
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  logic [PC_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] rd_q, rd_d, wr_q, wr_d, wr_base;
  // extra pointer MSB separates full from empty when the low bits match
  assign empty = rd_q == wr_q;
  assign full = (rd_q[FIFO_DEPTH_LOG2] != wr_q[FIFO_DEPTH_LOG2]) &&
                (rd_q[FIFO_DEPTH_LOG2-1:0] == wr_q[FIFO_DEPTH_LOG2-1:0]);
  assign head = mem_q[rd_q[FIFO_DEPTH_LOG2-1:0]];
  always_comb begin
    wr_base = clear ? '0 : wr_q;
    wr_d = wr_base + {{FIFO_DEPTH_LOG2{1'b0}}, push};
    rd_d = clear ? '0 : rd_q + {{FIFO_DEPTH_LOG2{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
    if (push) mem_q[wr_base[FIFO_DEPTH_LOG2-1:0]] <= din;
  end
endmodule

// File: rtl/pc_scheduler.sv
// pc_scheduler: ping-pong current/next PC queues around basic_block, character advance and match result
// ports: clk, reset (sync, active-low), start, cur_char_is_terminator, advance_valid/advance_ready,
//        bb_idle, bb_accepts, bus (in_pc/out_pc channels, slave side), busy, done, accepted
module pc_scheduler import pc_scheduler_pkg::*; #(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter int FIFO_DEPTH_LOG2 = DEFAULT_FIFO_DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cur_char_is_terminator,
  output logic        advance_valid,
  input  logic        advance_ready,
  input  logic        bb_idle,
  input  logic        bb_accepts,
  pc_scheduler_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic        accepted
);
  state_e state_q, state_d;
  logic cur_sel_q, cur_sel_d, accepted_q, accepted_d;
  logic [1:0] f_push, f_pop, f_clr, f_full, f_empty;
  logic [PC_WIDTH-1:0] f_din;
  logic [PC_WIDTH-1:0] f_head [2];
  logic run, cur_empty, nxt_empty, push, pop, exhausted, launch, dir;
  assign run = state_q == S_RUN;
  assign dir = bus.in_pc_is_directed_to_current;
  assign cur_empty = f_empty[cur_sel_q];
  assign nxt_empty = f_empty[~cur_sel_q];
  // readiness looks only at the target queue's registered full flag, never at out_pc_ready
  assign bus.in_pc_ready = run && !(dir ? f_full[cur_sel_q] : f_full[~cur_sel_q]);
  assign bus.out_pc_valid = run && !cur_empty;
  assign bus.out_pc = bus.out_pc_valid ? f_head[cur_sel_q] : '0;
  assign push = bus.in_pc_valid && bus.in_pc_ready && !bb_accepts;
  assign pop = bus.out_pc_valid && bus.out_pc_ready;
  assign exhausted = run && cur_empty && bb_idle && !bus.in_pc_valid && !push && !bb_accepts;
  assign launch = start && (state_q == S_IDLE || state_q == S_DONE);
  assign f_din = launch ? '0 : bus.in_pc;
  assign advance_valid = state_q == S_ADVANCE;
  assign busy = run || advance_valid;
  assign done = state_q == S_DONE;
  assign accepted = accepted_q;
  always_comb begin
    state_d = state_q;
    cur_sel_d = cur_sel_q;
    accepted_d = accepted_q;
    f_push = '0;
    f_pop = '0;
    f_clr = '0;
    f_push[cur_sel_q] = launch || (push && dir);
    f_push[~cur_sel_q] = push && !dir;
    f_pop[cur_sel_q] = pop;
    if (launch) begin
      f_clr = 2'b11;
      state_d = S_RUN;
      accepted_d = 1'b0;
    end else if (run && bb_accepts) begin
      f_clr = 2'b11;
      state_d = S_DONE;
      accepted_d = 1'b1;
    end else if (exhausted) begin
      state_d = (nxt_empty || cur_char_is_terminator) ? S_DONE : S_ADVANCE;
      f_clr[~cur_sel_q] = cur_char_is_terminator;
    end else if (advance_valid && advance_ready) begin
      cur_sel_d = ~cur_sel_q;
      state_d = S_RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cur_sel_q <= 1'b0;
      accepted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_sel_q <= cur_sel_d;
      accepted_q <= accepted_d;
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_q
    pc_fifo #(.PC_WIDTH(PC_WIDTH), .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
      .clk(clk),
      .reset(reset),
      .clear(f_clr[i]),
      .push(f_push[i]),
      .pop(f_pop[i]),
      .din(f_din),
      .head(f_head[i]),
      .full(f_full[i]),
      .empty(f_empty[i])
    );
  end
endmodule
